wh_link_stat_trigger: RTL and testbench

Upstream companion of the wormhole link profiler. It owns the free-running global cycle counter and turns host tag writes and periodic auto-sample ticks into properly spaced single-cycle print-stat pulses. Each pulse carries a tag. Its outputs drive global_ctr_i, print_stat_v_i and print_stat_tag_i of every profiler bound into the pod array.

---
 rtl/wh_link_stat_pkg.sv | 11 +
 rtl/bsg_fifo_1r1w_small.sv | 45 ++++
 rtl/wh_link_stat_trigger.sv | 86 ++++++++
 tb/tb_wh_link_stat_trigger.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/wh_link_stat_pkg.sv
// wh_link_stat_pkg: shared types and constants for the link-stat trigger and its profiler fan-out.
package wh_link_stat_pkg;
  localparam int data_width_lp = 32;
  localparam int auto_tag_bit = data_width_lp - 1;
  typedef enum logic {IDLE, GAP} state_e;
  typedef struct packed {
    logic [31:0]              global_ctr;
    logic                     print_stat_v;
    logic [data_width_lp-1:0] print_stat_tag;
  } stat_out_s;
endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small one-read one-write FIFO with occupancy count, async active-high reset.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 32,
  parameter int els_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);
  localparam int aw = $clog2(els_p);
  localparam int cw = $clog2(els_p+1);
  logic [width_p-1:0] mem_q [els_p];
  logic [aw-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cw-1:0] count_q, count_d;
  logic push, pop;
  always_comb begin
    ready_o = count_q != cw'(els_p);
    v_o = count_q != '0;
    data_o = mem_q[rptr_q];
    push = v_i & ready_o;
    pop = yumi_i & v_o;
    wptr_d = wptr_q + aw'(push);
    rptr_d = rptr_q + aw'(pop);
    count_d = count_q + cw'(push) - cw'(pop);
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk_i)
    if (push) mem_q[wptr_q] <= data_i;
  assign count_o = count_q;
endmodule

// File: rtl/wh_link_stat_trigger.sv
// wh_link_stat_trigger: global cycle counter plus spaced print-stat pulses from host tags and periodic auto ticks.
module wh_link_stat_trigger
  import wh_link_stat_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int fifo_els_p = 4,
  parameter int min_gap_p = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            en_i,
  input  logic                            req_v_i,
  input  logic [data_width_p-1:0]         req_tag_i,
  output logic                            req_ready_o,
  input  logic [31:0]                     period_i,
  output logic [31:0]                     global_ctr_o,
  output logic                            print_stat_v_o,
  output logic [data_width_p-1:0]         print_stat_tag_o,
  output logic [$clog2(fifo_els_p+1)-1:0] pending_o,
  output logic [31:0]                     dropped_o
);
  localparam int sw = data_width_p - 1;
  localparam int gw = $clog2(min_gap_p + 1);
  state_e state_q, state_d;
  logic [gw-1:0] gap_q, gap_d;
  logic [31:0] ctr_q, ctr_d, pc_q, pc_d, dropped_q, dropped_d;
  logic [sw-1:0] seq_q, seq_d;
  logic auto_pend_q, auto_pend_d, v_q, v_d;
  logic [data_width_p-1:0] tag_q, tag_d, push_tag, fifo_data;
  logic tick, host_push, auto_push, pop, fifo_ready, fifo_v;
  always_comb begin
    ctr_d = ctr_q + 32'(en_i);
    tick = (period_i != '0) & en_i & (pc_q >= period_i - 32'd1);
    pc_d = (period_i == '0 || tick) ? '0 : pc_q + 32'(en_i);
    host_push = req_v_i & fifo_ready;
    auto_push = auto_pend_q & fifo_ready & ~host_push;
    auto_pend_d = tick | (auto_pend_q & ~auto_push);
    dropped_d = (tick & auto_pend_q & ~auto_push & ~&dropped_q) ? dropped_q + 32'd1 : dropped_q;
    seq_d = seq_q + sw'(auto_push);
    push_tag = host_push ? req_tag_i : {1'b1, seq_q};
    pop = (state_q == IDLE) & fifo_v;
    v_d = pop;
    tag_d = pop ? fifo_data : tag_q;
    gap_d = (state_q == GAP) ? gap_q - 1'b1 : (pop ? gw'(min_gap_p - 1) : gap_q);
    state_d = (state_q == GAP) ? (gap_d == '0 ? IDLE : GAP) : ((pop && min_gap_p > 1) ? GAP : IDLE);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= IDLE;
      gap_q <= '0;
      ctr_q <= '0;
      pc_q <= '0;
      dropped_q <= '0;
      seq_q <= '0;
      auto_pend_q <= 1'b0;
      v_q <= 1'b0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      ctr_q <= ctr_d;
      pc_q <= pc_d;
      dropped_q <= dropped_d;
      seq_q <= seq_d;
      auto_pend_q <= auto_pend_d;
      v_q <= v_d;
      tag_q <= tag_d;
    end
  // The FIFO keeps its own active-high reset domain; feed it the inverted pin.
  bsg_fifo_1r1w_small #(.width_p(data_width_p), .els_p(fifo_els_p)) fifo (
    .clk_i(clk_i),
    .reset_i(~reset_n_i),
    .v_i(host_push | auto_push),
    .data_i(push_tag),
    .ready_o(fifo_ready),
    .v_o(fifo_v),
    .data_o(fifo_data),
    .yumi_i(pop),
    .count_o(pending_o)
  );
  assign req_ready_o = fifo_ready;
  assign global_ctr_o = ctr_q;
  assign print_stat_v_o = v_q;
  assign print_stat_tag_o = tag_q;
  assign dropped_o = dropped_q;
endmodule

// File: tb/tb_wh_link_stat_trigger.sv
// tb_wh_link_stat_trigger: directed checks of counter, host/auto pulses, FIFO back-pressure, drops and async reset.
module tb_wh_link_stat_trigger;
  logic clk = 1'b0;
  logic reset_n_i, en_i, req_v_i, req_ready_o, print_stat_v_o;
  logic [31:0] req_tag_i, period_i, global_ctr_o, print_stat_tag_o, dropped_o;
  logic [2:0] pending_o;
  int vectors = 0, miscompares = 0, cyc = 0;
  int pcyc[$];
  logic [31:0] ptag[$];
  int base;
  wh_link_stat_trigger dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .en_i(en_i), .req_v_i(req_v_i), .req_tag_i(req_tag_i),
    .req_ready_o(req_ready_o), .period_i(period_i), .global_ctr_o(global_ctr_o),
    .print_stat_v_o(print_stat_v_o), .print_stat_tag_o(print_stat_tag_o),
    .pending_o(pending_o), .dropped_o(dropped_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (print_stat_v_o) begin
      pcyc.push_back(cyc);
      ptag.push_back(print_stat_tag_o);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_pulse(input int i, input logic [31:0] tag, input int at);
    if (i < ptag.size()) begin
      chk("pulse_tag", ptag[i], tag);
      chk("pulse_cyc", 32'(pcyc[i]), 32'(at));
    end else chk("pulse_missing", 32'(ptag.size()), 32'(i + 1));
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear_log();
    pcyc.delete();
    ptag.delete();
  endtask
  initial begin
    reset_n_i = 1'b0; en_i = 1'b0; req_v_i = 1'b0; req_tag_i = '0; period_i = '0;
    #3;
    chk("rst_ctr", global_ctr_o, 0);
    chk("rst_v", 32'(print_stat_v_o), 0);
    chk("rst_tag", print_stat_tag_o, 0);
    chk("rst_pending", 32'(pending_o), 0);
    chk("rst_dropped", dropped_o, 0);
    // counter counts only when enabled
    @(negedge clk);
    reset_n_i = 1'b1; en_i = 1'b1;
    step(10);
    chk("ctr_10", global_ctr_o, 10);
    chk("ready_idle", 32'(req_ready_o), 1);
    chk("no_pulse", 32'(ptag.size()), 0);
    en_i = 1'b0;
    step(3);
    chk("ctr_hold", global_ctr_o, 10);
    en_i = 1'b1;
    // three host tags back to back, 8-cycle spacing
    base = cyc; clear_log();
    req_v_i = 1'b1; req_tag_i = 32'd5;
    step(1); req_tag_i = 32'd6;
    step(1); req_tag_i = 32'd7;
    step(1); req_v_i = 1'b0;
    chk("host_pending", 32'(pending_o), 2);
    step(37);
    chk("host_count", 32'(ptag.size()), 3);
    chk_pulse(0, 32'd5, base + 2);
    chk_pulse(1, 32'd6, base + 10);
    chk_pulse(2, 32'd7, base + 18);
    // auto ticks every 20 cycles
    base = cyc; clear_log();
    period_i = 32'd20;
    step(45);
    chk("auto_count", 32'(ptag.size()), 2);
    chk_pulse(0, 32'h8000_0000, base + 22);
    chk_pulse(1, 32'h8000_0001, base + 42);
    chk("auto_dropped", dropped_o, 0);
    chk("auto_pending", 32'(pending_o), 0);
    period_i = '0;
    step(10);
    // period 2 overruns the FIFO and starts dropping ticks
    base = cyc; clear_log();
    period_i = 32'd2;
    step(16);
    chk("ovf_drop16", dropped_o, 1);
    chk("ovf_pending", 32'(pending_o), 4);
    chk("ovf_ready", 32'(req_ready_o), 0);
    step(8);
    chk("ovf_drop24", dropped_o, 4);
    step(8);
    chk("ovf_drop32", dropped_o, 7);
    chk_pulse(0, 32'h8000_0002, base + 4);
    chk_pulse(1, 32'h8000_0003, base + 12);
    chk_pulse(2, 32'h8000_0004, base + 20);
    chk_pulse(3, 32'h8000_0005, base + 28);
    // async reset mid-gap with a full FIFO
    period_i = '0; reset_n_i = 1'b0;
    #1;
    chk("ar_ctr", global_ctr_o, 0);
    chk("ar_v", 32'(print_stat_v_o), 0);
    chk("ar_tag", print_stat_tag_o, 0);
    chk("ar_pending", 32'(pending_o), 0);
    chk("ar_dropped", dropped_o, 0);
    @(negedge clk);
    reset_n_i = 1'b1; clear_log();
    step(20);
    chk("ar_no_pulse", 32'(ptag.size()), 0);
    chk("ar_ready", 32'(req_ready_o), 1);
    // host request and tick together while FIFO holds 3
    base = cyc; clear_log();
    period_i = 32'd6;
    req_v_i = 1'b1; req_tag_i = 32'h11;
    step(1); req_tag_i = 32'h22;
    step(1); req_tag_i = 32'h33;
    step(1); req_tag_i = 32'h44;
    step(1); req_v_i = 1'b0;
    step(1); req_v_i = 1'b1; req_tag_i = 32'h55;
    step(1); req_v_i = 1'b0;
    chk("col_pending6", 32'(pending_o), 4);
    chk("col_ready", 32'(req_ready_o), 0);
    chk("col_dropped", dropped_o, 0);
    step(4);
    chk("col_pending10", 32'(pending_o), 3);
    step(1);
    chk("col_pending11", 32'(pending_o), 4);
    step(1); period_i = '0;
    step(32);
    chk("col_count", 32'(ptag.size()), 6);
    chk_pulse(0, 32'h11, base + 2);
    chk_pulse(1, 32'h22, base + 10);
    chk_pulse(2, 32'h33, base + 18);
    chk_pulse(3, 32'h44, base + 26);
    chk_pulse(4, 32'h55, base + 34);
    chk_pulse(5, 32'h8000_0000, base + 42);
    chk("col_pending44", 32'(pending_o), 1);
    chk("col_dropped_end", dropped_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
